// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_pkg
//  Purpose  : Shared definitions for the MEM-stage data-memory responder:
//             FSM state encodings, word geometry, the request record and
//             the request validation helper.
//  Revision : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // Responder FSM state encodings (shared with the MEM stage)
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Bytes per array word and the mask of byte-offset bits inside a word
    localparam int unsigned c_WORD_BYTES = 4;
    localparam logic [31:0] c_ALIGN_MASK = 32'(c_WORD_BYTES - 1);

    // Kind of access held while a request is in flight
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

    // Request captured when the flags are accepted in IDLE
    typedef struct packed {
        mem_op_e     op;
        logic        err;
        logic [31:0] wdata;
    } mem_req_t;

    // A request is rejected when both flags are set, the address is not
    // word aligned, or the unsigned offset from the base falls outside the
    // array. The offset is a plain 32-bit difference, so addresses below the
    // base wrap to a huge value and land out of range.
    function automatic logic req_rejected(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span_bytes
    );
        logic [31:0] offset;
        offset = addr - base;
        return (rd && wr)
            || ((addr & c_ALIGN_MASK) != 32'h0)
            || ({1'b0, offset} >= span_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram.sv
`default_nettype none
// ============================================================================
//  Module   : data_ram
//  Purpose  : Single-port DEPTH_WORDS x 32 data store. Synchronous write,
//             registered read with a read enable so the read register holds
//             its value between reads. Contents are never reset.
//  Revision : 1.0 - initial release
// ============================================================================
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rd_en,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata_q;

    // Write port: reset overrides the write enable so an abandoned request never commits
    always_ff @(posedge clk) begin
        if (i_we && !rst) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read register: captures the addressed word only when a read completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_q <= 32'h0;
        end else if (i_rd_en) begin
            r_rdata_q <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Responder end of the MEM-stage data-memory interface. Accepts
//             read/write flags in IDLE, validates the request, waits LATENCY
//             cycles and then completes it with a one-cycle ready pulse
//             (plus error for rejected requests).
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readFlag,
    input  logic        writeFlag,
    input  logic [31:0] addressIn,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int unsigned c_IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] c_SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(c_WORD_BYTES);
    localparam logic [3:0]  c_LAT_M1     = 4'(LATENCY - 1);

    logic [1:0]         r_state_q;
    logic [1:0]         w_state_d;
    logic [3:0]         r_cnt_q;
    logic [3:0]         w_cnt_d;
    mem_req_t           r_req_q;
    mem_req_t           w_req_d;
    logic [c_IDX_W-1:0] r_idx_q;
    logic [c_IDX_W-1:0] w_idx_d;

    logic               w_rejected;
    logic [c_IDX_W-1:0] w_in_idx;
    logic               w_ram_rd_en;
    logic               w_ram_we;
    logic [c_IDX_W-1:0] w_ram_idx;
    logic               w_in_resp;

    // Word index of the incoming address; high offset bits are dropped on purpose
    assign w_in_idx   = c_IDX_W'((addressIn - BASE_ADDR) >> 2);
    assign w_rejected = req_rejected(readFlag, writeFlag, addressIn, BASE_ADDR, c_SPAN_BYTES);

    // Next-state logic: accept in IDLE, count down in WAIT, single cycle in RESP
    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_req_d     = r_req_q;
        w_idx_d     = r_idx_q;
        w_ram_rd_en = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (readFlag || writeFlag) begin
                    // Both-flags requests are rejected, so op only matters when one flag is set
                    w_req_d.op    = writeFlag ? OP_WRITE : OP_READ;
                    w_req_d.err   = w_rejected;
                    w_req_d.wdata = dataIn;
                    w_idx_d       = w_in_idx;
                    if (w_rejected) begin
                        w_state_d = c_RESP;
                        w_cnt_d   = 4'd0;
                    end else if (c_LAT_M1 == 4'd0) begin
                        // Single-cycle latency: the read is issued straight from the bus address
                        w_state_d   = c_RESP;
                        w_cnt_d     = 4'd0;
                        w_ram_rd_en = !writeFlag;
                    end else begin
                        w_state_d = c_WAIT;
                        w_cnt_d   = c_LAT_M1;
                    end
                end
            end

            c_WAIT: begin
                w_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q == 4'd1) begin
                    // Counter hits zero on this edge: fetch the word so it is visible in RESP
                    w_state_d   = c_RESP;
                    w_ram_rd_en = (r_req_q.op == OP_READ);
                end
            end

            c_RESP: begin
                w_state_d = c_IDLE;
            end

            default: begin
                w_state_d = c_IDLE;
                w_cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and captured request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_IDLE;
            r_cnt_q   <= 4'd0;
            r_req_q   <= '0;
            r_idx_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_req_q   <= w_req_d;
            r_idx_q   <= w_idx_d;
        end
    end

    assign w_in_resp = (r_state_q == c_RESP);

    // Only the IDLE fast path reads from the bus; everything else uses the captured index
    assign w_ram_idx = (r_state_q == c_IDLE) ? w_in_idx : r_idx_q;

    // Writes commit at the end of RESP unless rejected or abandoned by reset
    assign w_ram_we  = w_in_resp && (r_req_q.op == OP_WRITE) && !r_req_q.err && !rst;

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_data_ram (
        .clk     (clk),
        .rst     (rst),
        .i_rd_en (w_ram_rd_en),
        .i_we    (w_ram_we),
        .i_idx   (w_ram_idx),
        .i_wdata (r_req_q.wdata),
        .o_rdata (dataOut)
    );

    // A reset arriving during RESP suppresses the completion pulse
    assign ready = w_in_resp && !rst;
    assign error = ready && r_req_q.err;
    assign busy  = (r_state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder with a cycle-level
//             reference model and directed request sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int unsigned c_DEPTH = 256;
    localparam int unsigned c_LAT   = 2;
    localparam logic [31:0] c_BASE  = 32'h0000_1000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        readFlag  = 1'b0;
    logic        writeFlag = 1'b0;
    logic [31:0] addressIn = 32'h0;
    logic [31:0] dataIn    = 32'h0;
    logic [31:0] dataOut;
    logic        ready;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (c_DEPTH),
        .LATENCY     (c_LAT),
        .BASE_ADDR   (c_BASE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .readFlag  (readFlag),
        .writeFlag (writeFlag),
        .addressIn (addressIn),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .ready     (ready),
        .busy      (busy),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [int];
    int          cyc       = 0;
    bit          m_live    = 1'b0;
    bit          m_pend    = 1'b0;
    int          m_resp    = 0;
    bit          m_err     = 1'b0;
    bit          m_wr      = 1'b0;
    int          m_idx     = 0;
    logic [31:0] m_wdata   = 32'h0;
    logic [31:0] m_rdval   = 32'h0;
    bit          m_rdknown = 1'b0;
    logic [31:0] m_dout    = 32'h0;
    bit          m_dknown  = 1'b0;
    int          ready_cycles[$];

    function automatic bit m_reject(input bit rd, input bit wr, input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, c_BASE});
        return (rd && wr) || (a % 4 != 0) || (off < 0) || (off >= longint'(c_DEPTH) * 4);
    endfunction

    function automatic int m_index(input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, c_BASE});
        return int'(off / 4);
    endfunction

    // Model advances on the rising edge; DUT outputs are compared mid-cycle
    always begin
        @(posedge clk);
        if (rst) begin
            m_live   = 1'b1;
            m_pend   = 1'b0;
            m_dout   = 32'h0;
            m_dknown = 1'b1;
        end else if (m_live) begin
            if (m_pend && cyc == m_resp) begin
                if (m_wr && !m_err) m_mem[m_idx] = m_wdata;
                m_pend = 1'b0;
            end else if (!m_pend && (readFlag || writeFlag)) begin
                m_err   = m_reject(readFlag, writeFlag, addressIn);
                m_wr    = writeFlag;
                m_wdata = dataIn;
                m_resp  = cyc + (m_err ? 1 : int'(c_LAT));
                m_pend  = 1'b1;
                if (!m_err) m_idx = m_index(addressIn);
                if (!m_err && !m_wr) begin
                    m_rdknown = m_mem.exists(m_idx);
                    m_rdval   = m_rdknown ? m_mem[m_idx] : 32'h0;
                end
            end
        end
        cyc++;
        if (m_pend && !m_err && !m_wr && cyc == m_resp) begin
            m_dout   = m_rdval;
            m_dknown = m_rdknown;
        end
        @(negedge clk);
        #1;
        if (m_live) begin
            check("ready", 32'(ready), 32'(m_pend && cyc == m_resp && !rst));
            check("error", 32'(error), 32'(m_pend && cyc == m_resp && !rst && m_err));
            check("busy",  32'(busy),  32'(m_pend));
            if (m_dknown) check("dataOut", dataOut, m_dout);
            if (ready === 1'b1) ready_cycles.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input bit noise, output int lat, output logic err, output logic [31:0] dout);
        @(negedge clk);
        readFlag  = rd;
        writeFlag = wr;
        addressIn = addr;
        dataIn    = data;
        @(negedge clk);
        readFlag  = 1'b0;
        writeFlag = 1'b0;
        lat = 1;
        while (ready !== 1'b1 && lat < 20) begin
            if (noise) begin
                readFlag  = 1'($urandom);
                writeFlag = 1'($urandom);
                addressIn = $urandom;
                dataIn    = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        check("req_timeout", 32'(ready), 32'h1);
        err       = error;
        dout      = dataOut;
        readFlag  = 1'b0;
        writeFlag = 1'b0;
        @(negedge clk);
    endtask

    int          lat;
    logic        err;
    logic [31:0] dout;
    int          k;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dataOut", dataOut, 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_ready",   32'(ready), 32'h0);
        check("rst_error",   32'(error), 32'h0);
        rst = 1'b0;

        // Write then read back
        req(1'b0, 1'b1, c_BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, lat, err, dout);
        check("wr_latency", 32'(lat), 32'd2);
        check("wr_error",   32'(err), 32'h0);
        req(1'b1, 1'b0, c_BASE + 32'h10, 32'h0, 1'b0, lat, err, dout);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_data",    dout, 32'hDEAD_BEEF);

        // Misaligned read is rejected after one cycle, data unchanged
        req(1'b1, 1'b0, c_BASE + 32'h13, 32'h0, 1'b0, lat, err, dout);
        check("misal_latency", 32'(lat), 32'd1);
        check("misal_error",   32'(err), 32'h1);
        check("misal_data",    dout, 32'hDEAD_BEEF);

        // Both flags: rejected, no write
        req(1'b0, 1'b1, c_BASE + 32'h20, 32'h1111_2222, 1'b0, lat, err, dout);
        req(1'b1, 1'b1, c_BASE + 32'h20, 32'h9999_9999, 1'b0, lat, err, dout);
        check("both_error", 32'(err), 32'h1);
        req(1'b1, 1'b0, c_BASE + 32'h20, 32'h0, 1'b0, lat, err, dout);
        check("both_nowrite", dout, 32'h1111_2222);

        // Out-of-range addresses alias onto index 0 and the last word if mishandled
        req(1'b0, 1'b1, c_BASE,          32'h0F0F_0F0F, 1'b0, lat, err, dout);
        req(1'b0, 1'b1, c_BASE + 32'h3FC, 32'h5A5A_5A5A, 1'b0, lat, err, dout);
        check("last_word_ok", 32'(err), 32'h0);
        req(1'b0, 1'b1, c_BASE + 32'h400, 32'hBAD0_0001, 1'b0, lat, err, dout);
        check("over_error", 32'(err), 32'h1);
        req(1'b0, 1'b1, c_BASE - 32'h4,   32'hBAD0_0002, 1'b0, lat, err, dout);
        check("under_error", 32'(err), 32'h1);
        req(1'b1, 1'b0, 32'h0000_0000,    32'h0, 1'b0, lat, err, dout);
        check("wrap_error", 32'(err), 32'h1);
        req(1'b1, 1'b0, c_BASE,           32'h0, 1'b0, lat, err, dout);
        check("word0_kept", dout, 32'h0F0F_0F0F);
        req(1'b1, 1'b0, c_BASE + 32'h3FC, 32'h0, 1'b0, lat, err, dout);
        check("wordlast_kept", dout, 32'h5A5A_5A5A);

        // Flags toggled while busy are ignored
        req(1'b0, 1'b1, c_BASE + 32'h30, 32'h1357_2468, 1'b1, lat, err, dout);
        check("noise_latency", 32'(lat), 32'd2);
        req(1'b1, 1'b0, c_BASE + 32'h30, 32'h0, 1'b0, lat, err, dout);
        check("noise_data", dout, 32'h1357_2468);

        // writeFlag held high: back-to-back requests every LATENCY+1 cycles
        ready_cycles.delete();
        @(negedge clk);
        writeFlag = 1'b1;
        addressIn = c_BASE + 32'h40;
        dataIn    = 32'h0000_00A0;
        k = 0;
        for (int i = 0; i < 30 && k < 3; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                k++;
                addressIn = addressIn + 32'h4;
                dataIn    = dataIn + 32'h1;
            end
        end
        writeFlag = 1'b0;
        @(negedge clk);
        #2;
        check("cont_pulses", 32'(ready_cycles.size()), 32'd3);
        if (ready_cycles.size() >= 3) begin
            check("cont_gap1", 32'(ready_cycles[1] - ready_cycles[0]), 32'd3);
            check("cont_gap2", 32'(ready_cycles[2] - ready_cycles[1]), 32'd3);
        end
        req(1'b1, 1'b0, c_BASE + 32'h44, 32'h0, 1'b0, lat, err, dout);
        check("cont_data", dout, 32'h0000_00A1);

        // Reset during the RESP cycle of a write blocks the commit and the pulse
        req(1'b0, 1'b1, c_BASE + 32'h8, 32'hCAFE_F00D, 1'b0, lat, err, dout);
        @(negedge clk);
        writeFlag = 1'b1;
        addressIn = c_BASE + 32'h8;
        dataIn    = 32'h1234_5678;
        @(negedge clk);
        writeFlag = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_resp_ready", 32'(ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_dataOut", dataOut, 32'h0);
        check("rst_mid_busy",    32'(busy), 32'h0);
        req(1'b1, 1'b0, c_BASE + 32'h8, 32'h0, 1'b0, lat, err, dout);
        check("rst_nocommit", dout, 32'hCAFE_F00D);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
